// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up sequencer: pulses porst, waits for the core to settle, then qualifies
// the synchronized vbg_ok flag, re-kicking a bounded number of times before giving up.
module bgr_startup_ctrl #(
  parameter int PULSE_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CHECK_CYCLES  = 2048,
  parameter int OK_FILTER     = 8,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vbg_ok,
  output logic       porst,
  output logic       bgr_ready,
  output logic       bgr_fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KICK   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    READY  = 3'd4,
    FAIL   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(OK_FILTER - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  generate
    if (PULSE_CYCLES < 1 || SETTLE_CYCLES < 1 || OK_FILTER < 1 ||
        CHECK_CYCLES < OK_FILTER || MAX_RETRY < 0 || MAX_RETRY > 15 ||
        PULSE_CYCLES > (1 << CNT_W) || SETTLE_CYCLES > (1 << CNT_W) ||
        CHECK_CYCLES > (1 << CNT_W)) begin : g_bad_params
      $error("bgr_startup_ctrl: illegal parameter combination");
    end
  endgenerate

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] filt;
  logic             sync1;
  logic             vs;
  logic             pass;
  logic             timeout;
  logic             loss;

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      vs    <= 1'b0;
    end else begin
      sync1 <= vbg_ok;
      vs    <= sync1;
    end
  end

  // A pass in the last CHECK cycle beats the timeout.
  assign pass    = (st == CHECK) && vs && (filt == FILT_LAST);
  assign timeout = (st == CHECK) && !pass && (cnt == CHECK_LAST);
  assign loss    = (st == READY) && !vs && (filt == FILT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      filt      <= '0;
      retry_cnt <= 4'd0;
      porst     <= 1'b0;
      bgr_ready <= 1'b0;
      bgr_fail  <= 1'b0;
    end else if (!en) begin
      st        <= IDLE;
      cnt       <= '0;
      filt      <= '0;
      retry_cnt <= 4'd0;
      porst     <= 1'b0;
      bgr_ready <= 1'b0;
      bgr_fail  <= 1'b0;
    end else if (timeout || loss) begin
      cnt       <= '0;
      filt      <= '0;
      bgr_ready <= 1'b0;
      if (retry_cnt >= RETRY_MAX) begin
        st       <= FAIL;
        porst    <= 1'b0;
        bgr_fail <= 1'b1;
      end else begin
        st        <= KICK;
        porst     <= 1'b1;
        retry_cnt <= retry_cnt + 4'd1;
      end
    end else begin
      case (st)
        IDLE: begin
          st    <= KICK;
          porst <= 1'b1;
          cnt   <= '0;
        end
        KICK: begin
          if (cnt == PULSE_LAST) begin
            st    <= SETTLE;
            porst <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            st   <= CHECK;
            cnt  <= '0;
            filt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (pass) begin
            st        <= READY;
            bgr_ready <= 1'b1;
            cnt       <= '0;
            filt      <= '0;
          end else begin
            cnt  <= cnt + 1'b1;
            filt <= vs ? filt + 1'b1 : '0;
          end
        end
        READY: begin
          filt <= vs ? '0 : filt + 1'b1;
        end
        FAIL: begin
          bgr_fail <= 1'b1;
        end
        default: begin
          st        <= IDLE;
          porst     <= 1'b0;
          bgr_ready <= 1'b0;
          bgr_fail  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Directed bench for bgr_startup_ctrl with short phase lengths; edges are counted from en=1.
module tb_bgr_startup_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       vbg_ok;
  logic       porst;
  logic       bgr_ready;
  logic       bgr_fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  bgr_startup_ctrl #(
    .PULSE_CYCLES (4),
    .SETTLE_CYCLES(16),
    .CHECK_CYCLES (32),
    .OK_FILTER    (4),
    .MAX_RETRY    (2),
    .CNT_W        (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .vbg_ok   (vbg_ok),
    .porst    (porst),
    .bgr_ready(bgr_ready),
    .bgr_fail (bgr_fail),
    .retry_cnt(retry_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Each tick lets exactly one rising edge pass and returns on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; vbg_ok = 1'b1;
    tick(2);
    checks++;
    if ({porst, bgr_ready, bgr_fail, retry_cnt, state} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs: got p=%b r=%b f=%b rc=%0d st=%0d want all 0",
               porst, bgr_ready, bgr_fail, retry_cnt, state);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    logic       exp_p;
    logic [2:0] exp_st;
    tick(10);
    checks++;
    if (state !== 3'd0 || porst !== 1'b0) begin
      failures++;
      $display("FAIL nominal_idle: st=%0d porst=%b want st=0 porst=0", state, porst);
    end
    en = 1'b1;
    for (int e = 11; e <= 35; e++) begin
      tick(1);
      exp_p  = (e <= 14);
      exp_st = (e <= 14) ? 3'd1 : (e <= 30) ? 3'd2 : (e <= 34) ? 3'd3 : 3'd4;
      checks++;
      if (porst !== exp_p || state !== exp_st || bgr_ready !== (e == 35)) begin
        failures++;
        $display("FAIL nominal_edge%0d: p=%b st=%0d rdy=%b want p=%b st=%0d rdy=%b",
                 e, porst, state, bgr_ready, exp_p, exp_st, (e == 35));
      end
    end
    checks++;
    if (retry_cnt !== 4'd0 || bgr_fail !== 1'b0) begin
      failures++;
      $display("FAIL nominal_ready: rc=%0d fail=%b want rc=0 fail=0", retry_cnt, bgr_fail);
    end
  endtask

  task automatic test_never_good;
    int   exp_t[3]  = '{1, 53, 105};
    int   exp_rc[3] = '{0, 1, 2};
    int   rise_t[3];
    int   rise_rc[3];
    int   n_rise = 0;
    int   high_cnt = 0;
    logic prev = 1'b0;
    en = 1'b0; vbg_ok = 1'b0;
    tick(3);
    en = 1'b1;
    for (int t = 1; t <= 170; t++) begin
      tick(1);
      if (porst) high_cnt++;
      if (porst && !prev && n_rise < 3) begin
        rise_t[n_rise]  = t;
        rise_rc[n_rise] = int'(retry_cnt);
        n_rise++;
      end
      prev = porst;
      if (t == 156) begin
        checks++;
        if (state !== 3'd3 || bgr_fail !== 1'b0) begin
          failures++;
          $display("FAIL ng_last_check: st=%0d fail=%b want st=3 fail=0", state, bgr_fail);
        end
      end
      if (t == 157) begin
        checks++;
        if (state !== 3'd5 || bgr_fail !== 1'b1) begin
          failures++;
          $display("FAIL ng_fail_entry: st=%0d fail=%b want st=5 fail=1", state, bgr_fail);
        end
      end
    end
    checks++;
    if (n_rise !== 3 || high_cnt !== 12) begin
      failures++;
      $display("FAIL ng_pulses: rises=%0d high=%0d want rises=3 high=12", n_rise, high_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < n_rise) begin
        checks++;
        if (rise_t[i] !== exp_t[i] || rise_rc[i] !== exp_rc[i]) begin
          failures++;
          $display("FAIL ng_kick%0d: edge=%0d rc=%0d want edge=%0d rc=%0d",
                   i, rise_t[i], rise_rc[i], exp_t[i], exp_rc[i]);
        end
      end
    end
    checks++;
    if (bgr_fail !== 1'b1 || porst !== 1'b0 || retry_cnt !== 4'd2 || bgr_ready !== 1'b0) begin
      failures++;
      $display("FAIL ng_sticky: fail=%b p=%b rc=%0d rdy=%b want 1 0 2 0",
               bgr_fail, porst, retry_cnt, bgr_ready);
    end
  endtask

  task automatic test_abort;
    en = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd0 || bgr_fail !== 1'b0 || retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL abort_fail_clear: st=%0d fail=%b rc=%0d want 0 0 0", state, bgr_fail, retry_cnt);
    end
    en = 1'b1;
    tick(2);
    checks++;
    if (porst !== 1'b1 || state !== 3'd1) begin
      failures++;
      $display("FAIL abort_kick2: p=%b st=%0d want p=1 st=1", porst, state);
    end
    en = 1'b0;
    tick(1);
    checks++;
    if (porst !== 1'b0 || state !== 3'd0) begin
      failures++;
      $display("FAIL abort_drop: p=%b st=%0d want p=0 st=0", porst, state);
    end
    en = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      checks++;
      if (porst !== (e <= 4) || retry_cnt !== 4'd0) begin
        failures++;
        $display("FAIL abort_repulse%0d: p=%b rc=%0d want p=%b rc=0", e, porst, retry_cnt, (e <= 4));
      end
    end
  endtask

  task automatic test_glitch;
    int seen_ready = 0;
    en = 1'b0;
    tick(1);
    en = 1'b1;
    for (int t = 1; t <= 53; t++) begin
      vbg_ok = ((t - 1) % 4) != 3;
      tick(1);
      if (state === 3'd4) seen_ready++;
    end
    checks++;
    if (seen_ready !== 0 || state !== 3'd1 || retry_cnt !== 4'd1) begin
      failures++;
      $display("FAIL glitch_timeout: ready_cycles=%0d st=%0d rc=%0d want 0 1 1",
               seen_ready, state, retry_cnt);
    end
    vbg_ok = 1'b0;
    tick(20);
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL glitch_check2: st=%0d want 3", state);
    end
    vbg_ok = 1'b1;
    tick(5);
    checks++;
    if (state !== 3'd3 || bgr_ready !== 1'b0) begin
      failures++;
      $display("FAIL glitch_early: st=%0d rdy=%b want st=3 rdy=0", state, bgr_ready);
    end
    tick(1);
    checks++;
    if (state !== 3'd4 || bgr_ready !== 1'b1 || retry_cnt !== 4'd1) begin
      failures++;
      $display("FAIL glitch_ready: st=%0d rdy=%b rc=%0d want 4 1 1", state, bgr_ready, retry_cnt);
    end
  endtask

  task automatic test_loss;
    int drops = 0;
    en = 1'b0; vbg_ok = 1'b1;
    tick(3);
    en = 1'b1;
    tick(25);
    checks++;
    if (state !== 3'd4 || bgr_ready !== 1'b1) begin
      failures++;
      $display("FAIL loss_ready: st=%0d rdy=%b want st=4 rdy=1", state, bgr_ready);
    end
    vbg_ok = 1'b0;
    for (int t = 0; t < 11; t++) begin
      if (t == 3) vbg_ok = 1'b1;
      tick(1);
      if (bgr_ready !== 1'b1) drops++;
    end
    checks++;
    if (drops !== 0) begin
      failures++;
      $display("FAIL loss_short_burst: ready dropped %0d cycles want 0", drops);
    end
    vbg_ok = 1'b0;
    tick(5);
    checks++;
    if (bgr_ready !== 1'b1 || porst !== 1'b0) begin
      failures++;
      $display("FAIL loss_before: rdy=%b p=%b want rdy=1 p=0", bgr_ready, porst);
    end
    tick(1);
    checks++;
    if (bgr_ready !== 1'b0 || porst !== 1'b1 || state !== 3'd1 || retry_cnt !== 4'd1) begin
      failures++;
      $display("FAIL loss_rekick: rdy=%b p=%b st=%0d rc=%0d want 0 1 1 1",
               bgr_ready, porst, state, retry_cnt);
    end
  endtask

  task automatic test_async_reset;
    en = 1'b0;
    tick(1);
    en = 1'b1; vbg_ok = 1'b1;
    tick(10);
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL async_settle: st=%0d want 2", state);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({porst, bgr_ready, bgr_fail, retry_cnt, state} !== 10'b0) begin
      failures++;
      $display("FAIL async_immediate: p=%b r=%b f=%b rc=%0d st=%0d want all 0",
               porst, bgr_ready, bgr_fail, retry_cnt, state);
    end
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd1 || porst !== 1'b1 || retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL async_restart: st=%0d p=%b rc=%0d want 1 1 0", state, porst, retry_cnt);
    end
    tick(4);
    checks++;
    if (state !== 3'd2 || porst !== 1'b0) begin
      failures++;
      $display("FAIL async_settle2: st=%0d p=%b want st=2 p=0", state, porst);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_never_good();
    test_abort();
    test_glitch();
    test_loss();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
